// File: rtl/datamem_arbiter.sv
// datamem_arbiter: round-robin arbiter sharing one single-port data memory among NUM_REQ requesters
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/we/lock : per-requester request, write select, hold-ownership flag
//   req_addr/wdata    : flattened per-requester address and write data
//   req_ready         : one-hot accept strobe (transfer = valid & ready)
//   rsp_valid/rdata   : one-hot read-data strobe and shared read-data bus
//   mem_*             : single-port memory interface, read data valid the cycle after mem_memread
//   Optional macro DATAMEM_ARB_PRIO0_EN: requester 0 gets fixed priority over unlocked round-robin.
module datamem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_writedata,
  output logic                      mem_memwrite,
  output logic                      mem_memread,
  input  logic [DATA_W-1:0]         mem_readdata
);
`ifdef DATAMEM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic {IDLE, READ_WAIT} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, owner, win, inc, ptr_nx;
  logic locked, grant;
  // Grants are gated by rst_n so every memory control drops the moment reset asserts.
  // The scan runs from the farthest candidate down so the nearest one to rr_ptr wins.
  always_comb begin
    grant = 1'b0;
    win = '0;
    if (rst_n && state == IDLE) begin
      if (locked) begin
        grant = req_valid[owner];
        win = owner;
      end else if (PRIO0 && req_valid[0]) begin
        grant = 1'b1;
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--)
          if (req_valid[(int'(rr_ptr) + k) % NUM_REQ] && !(PRIO0 && (int'(rr_ptr) + k) % NUM_REQ == 0)) begin
            grant = 1'b1;
            win = PW'((int'(rr_ptr) + k) % NUM_REQ);
          end
      end
    end
  end
  // With fixed priority, a requester-0 grant leaves the rotation alone and the pointer never lands on 0.
  assign inc = PW'((int'(win) + 1) % NUM_REQ);
  assign ptr_nx = !PRIO0 ? inc : win == '0 ? rr_ptr : inc == '0 ? PW'(1) : inc;
  always_comb begin
    req_ready = '0;
    req_ready[win] = grant;
    mem_memwrite = grant & req_we[win];
    mem_memread = grant & ~req_we[win];
    mem_address = grant ? req_addr[int'(win)*ADDR_W +: ADDR_W] : '0;
    mem_writedata = grant ? req_wdata[int'(win)*DATA_W +: DATA_W] : '0;
    state_nx = mem_memread ? READ_WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      locked <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      rsp_valid <= '0;
      if (state == READ_WAIT) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata <= mem_readdata;
      end
      if (grant) begin
        locked <= req_lock[win];
        if (req_lock[win] || !req_we[win])
          owner <= win;
        if (!req_lock[win])
          rr_ptr <= ptr_nx;
      end else if (locked && state == IDLE)
        locked <= 1'b0;
    end
endmodule
